simon_playback: RTL

Playback sequencer for the Simon game: the reader side of the pattern store that the datapath writes during input mode. On a start request it walks the stored patterns in order, presenting each one on the pattern LEDs for exactly one clock, then signals completion. Sits between the pattern memory's read port and the LED output mux. It advances on the same user clock as the rest of the game, so each `clk` edge is one displayed step.

---
 rtl/simon_playback.sv | 97 +++++++++
 1 files changed

// File: rtl/simon_playback.sv
// Simon playback sequencer: walks the stored pattern memory and shows one entry per clock.
// Define SIMON_PLAYBACK_GAP_EN to insert one blank cycle between consecutive entries.
module simon_playback #(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned WIDTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DEPTH_LOG2:0]   seq_len,
  input  logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      leds,
  output logic                  busy,
  output logic                  done
);

`ifdef SIMON_PLAYBACK_GAP_EN
  typedef enum logic [1:0] {StIdle, StShow, StGap, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShow, StDone} state_e;
`endif

  localparam logic [DEPTH_LOG2:0] MaxLen = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] IdxOne = {{DEPTH_LOG2{1'b0}}, 1'b1};

  state_e                state_q;
  logic [DEPTH_LOG2:0]   idx_q;
  logic [DEPTH_LOG2:0]   len_q;
  logic [DEPTH_LOG2:0]   len_clamped;

  assign len_clamped = (seq_len > MaxLen) ? MaxLen : seq_len;

  // idx reaches 2^DEPTH_LOG2 only after the last entry of a full run; hold the
  // address at the top entry there instead of letting it wrap back to 0.
  assign rd_addr = idx_q[DEPTH_LOG2] ? {DEPTH_LOG2{1'b1}} : idx_q[DEPTH_LOG2-1:0];

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      leds    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            if (seq_len != '0) begin
              leds    <= rd_data;
              idx_q   <= IdxOne;
              len_q   <= len_clamped;
              busy    <= 1'b1;
              state_q <= StShow;
            end else begin
              done    <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StShow: begin
          if (idx_q < len_q) begin
`ifdef SIMON_PLAYBACK_GAP_EN
            leds    <= '0;
            state_q <= StGap;
`else
            leds    <= rd_data;
            idx_q   <= idx_q + IdxOne;
`endif
          end else begin
            leds    <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
`ifdef SIMON_PLAYBACK_GAP_EN
        StGap: begin
          leds    <= rd_data;
          idx_q   <= idx_q + IdxOne;
          state_q <= StShow;
        end
`endif
        StDone: begin
          done    <= 1'b0;
          idx_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
